uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//  UART serializer; transmit-side counterpart of the 16x-oversampling UART receiver.
//  Accepts a byte on a single-cycle write strobe. Emits one frame: start bit (0),
//  8 data bits LSB first, optional parity bit, 1 or 2 stop bits (1). Each bit lasts
//  16 clk_en ticks, driven from the same baud-tick generator as the receiver.
// PARAMETERS
//  PARITY_EN   0  1 = insert a parity bit after data bit 7; 0 = no parity bit.
//  PARITY_ODD  0  1 = odd parity, 0 = even parity (ignored when PARITY_EN=0).
//  STOP_BITS   1  number of stop bits, 1 or 2.
//  Defaults (8N1) are the receiver-compatible frame.
// PORTS
//  clk     in   1  system clock, all logic on posedge.
//  reset   in   1  asynchronous, active-high reset.
//  clk_en  in   1  16x baud tick, one clk cycle wide.
//  wr_en   in   1  write strobe; din is accepted when wr_en=1 and tx_busy=0.
//  din     in   8  byte to transmit.
//  tx      out  1  serial line, idles high.
//  tx_busy out  1  high from the cycle after acceptance until the frame ends.
//  done    out  1  one-clk pulse when the last stop bit completes.
// BEHAVIOUR
//  Reset (async, any state): tx=1, tx_busy=0, done=0, state=IDLE, tick_cnt=0,
//   bit_idx=0, shift register=0. A frame in progress is abandoned. No partial bits.
//  All outputs are registered.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE: tx=1. If wr_en & !tx_busy on a clk edge (clk_en not required):
//   - latch din
//   - compute parity = ^din ^ PARITY_ODD
//   - tick_cnt=0; go to START.
//   On the next cycle tx=0 and tx_busy=1.
//  tick_cnt (4 bits) advances only on cycles with clk_en=1. A bit ends on the
//   clk_en tick where tick_cnt==15. tick_cnt wraps to 0 and the next bit's value
//   appears on tx in the following cycle. So each bit = exactly 16 clk_en ticks.
//  START: tx=0 for 16 ticks, then DATA with bit_idx=0.
//  DATA: tx=shift[0] for 16 ticks, then shift right and increment bit_idx.
//   After bit_idx==7 completes: go to PARITY if PARITY_EN, else STOP.
//  PARITY: tx=parity bit for 16 ticks, then STOP.
//  STOP: tx=1 for 16*STOP_BITS ticks. Then go to IDLE, tx_busy=0, done=1 for
//   exactly one clk.
//  wr_en while tx_busy=1 is ignored: no latch, no effect on the current frame.
//  wr_en in the same cycle that done pulses is accepted (tx_busy already 0).
//   This gives back-to-back frames with no extra idle.
//  clk_en=0 holds tx, tick_cnt and state frozen. Only acceptance from IDLE proceeds.
//  din changes after acceptance do not affect the frame in flight.
//  Frame length 8N1 = 160 ticks; 8E1/8O1 = 176 ticks; 8N2 = 176 ticks.
//  Illegal state encoding recovers to IDLE with tx=1.
// TESTING
//  1. Defaults, din=8'hA5, clk_en every 4th clk -> tx bits 0,1,0,1,0,0,1,0,1,1,
//     each 16 ticks. tx_busy high 160 ticks. One done pulse at the end.
//  2. Loopback tx->rx of receiver, send 8'h00, 8'hFF, 8'h3C back-to-back via
//     done -> rx dout matches each byte, ready asserted. No idle gap between frames.
//  3. PARITY_EN=1, PARITY_ODD=0, din=8'h07 -> parity bit 1.
//     PARITY_ODD=1 -> parity bit 0. Frame 176 ticks.
//  4. wr_en with din=8'h55 at tick 40 of a frame carrying 8'hA5 -> ignored;
//     frame bits unchanged; only one done pulse.
//  5. reset asserted mid-DATA (bit 3), asynchronous to clk -> tx=1 and tx_busy=0
//     immediately. The next wr_en sends a clean full frame.
//  6. clk_en held 0 for 100 clk during bit 5 -> tx constant. Bit resumes and
//     totals 16 ticks. STOP_BITS=2 -> stop high for 32 ticks.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART serializer: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Each bit lasts 16 clk_en ticks so it pairs with the 16x-oversampling receiver.
module uart_transmitter #(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       done
);

    localparam logic       ODD       = (PARITY_ODD != 0);
    localparam logic [2:0] LAST_STOP = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic       parity;
    logic       bit_end;

    assign bit_end = clk_en && (tick_cnt == 4'd15);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= 4'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            parity   <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            // tick_cnt wraps naturally from 15 to 0 at each bit boundary
            if (state != IDLE && clk_en)
                tick_cnt <= tick_cnt + 4'd1;

            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (wr_en) begin
                        shift    <= din;
                        parity   <= (^din) ^ ODD;
                        tick_cnt <= 4'd0;
                        bit_idx  <= 3'd0;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx      <= shift[0];
                        bit_idx <= 3'd0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            if (PARITY_EN != 0) begin
                                tx    <= parity;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    // bit_idx counts completed stop bits here
                    if (bit_end) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= 3'd0;
                            tx_busy <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= 4'd0;
                    bit_idx  <= 3'd0;
                    tx       <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances (8N1, 8E1, 8O2) share clk/clk_en/din;
// a monitor captures each frame bit-by-bit on clk_en ticks and compares to hand values.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_en = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr     [3];
    logic       tx_v   [3];
    logic       busy_v [3];
    logic       done_v [3];

    int          tick_n      [3];
    logic [11:0] cur_bits    [3];
    logic        cur_bad     [3];
    logic [11:0] frame_bits  [3];
    logic        frame_bad   [3];
    int          frame_ticks [3];
    int          done_cnt    [3];

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          inst;
        logic [7:0]  d;
        logic [11:0] exp;
        int          ticks;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    uart_transmitter #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_n1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .wr_en(wr[0]), .din(din),
        .tx(tx_v[0]), .tx_busy(busy_v[0]), .done(done_v[0]));
    uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .wr_en(wr[1]), .din(din),
        .tx(tx_v[1]), .tx_busy(busy_v[1]), .done(done_v[1]));
    uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_o2 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .wr_en(wr[2]), .din(din),
        .tx(tx_v[2]), .tx_busy(busy_v[2]), .done(done_v[2]));

    // baud tick every 4th clk, suppressed while hold is set
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 clk_en = !hold;
            @(posedge clk);
            #1 clk_en = 1'b0;
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                tick_n[i]   <= 0;
                cur_bits[i] <= 12'h000;
                cur_bad[i]  <= 1'b0;
            end else if (done_v[i]) begin
                frame_ticks[i] <= tick_n[i];
                frame_bits[i]  <= cur_bits[i];
                frame_bad[i]   <= cur_bad[i];
                done_cnt[i]    <= done_cnt[i] + 1;
                tick_n[i]      <= 0;
                cur_bits[i]    <= 12'h000;
                cur_bad[i]     <= 1'b0;
            end else if (busy_v[i] && clk_en) begin
                if (tick_n[i] >= 192)
                    cur_bad[i] <= 1'b1;
                else if (tick_n[i] % 16 == 0)
                    cur_bits[i][tick_n[i] / 16] <= tx_v[i];
                else if (cur_bits[i][tick_n[i] / 16] != tx_v[i])
                    cur_bad[i] <= 1'b1;
                tick_n[i] <= tick_n[i] + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send(input int i, input logic [7:0] d);
        @(posedge clk);
        #1;
        din   = d;
        wr[i] = 1'b1;
        @(posedge clk);
        #1;
        wr[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int start, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 4000) begin
            @(negedge clk);
            #1;
            if (done_cnt[i] != start) ok = 1'b1;
            n++;
        end
    endtask

    task automatic wait_tick(input int i, input int t, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 4000) begin
            @(negedge clk);
            #1;
            if (tick_n[i] >= t) ok = 1'b1;
            n++;
        end
    endtask

    task automatic check_frame(input string name, input int i, input logic [11:0] exp,
                               input int ticks);
        chk({name, "_bits"}, 32'(frame_bits[i]), 32'(exp));
        chk({name, "_ticks"}, frame_ticks[i], ticks);
        chk({name, "_steady"}, 32'(frame_bad[i]), 32'd0);
    endtask

    task automatic run_frame(input string name, input int i, input logic [7:0] d,
                             input logic [11:0] exp, input int ticks);
        int start;
        bit ok;
        start = done_cnt[i];
        send(i, d);
        wait_done(i, start, ok);
        chk({name, "_done_seen"}, 32'(ok), 32'd1);
        check_frame(name, i, exp, ticks);
        @(negedge clk);
        #1;
        chk({name, "_one_done"}, done_cnt[i], start + 1);
    endtask

    initial begin
        int  start;
        bit  ok;
        bit  steady;
        logic ref_tx;
        int  ref_tick;

        for (int i = 0; i < 3; i++) wr[i] = 1'b0;
        vecs[0] = '{0, 8'hA5, 12'h34A, 160};
        vecs[1] = '{0, 8'h3C, 12'h278, 160};
        vecs[2] = '{1, 8'h07, 12'h60E, 176};
        vecs[3] = '{1, 8'hA5, 12'h54A, 176};
        vecs[4] = '{2, 8'h07, 12'hC0E, 192};
        vecs[5] = '{2, 8'hA5, 12'hF4A, 192};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_tx%0d", i), 32'(tx_v[i]), 32'd1);
            chk($sformatf("reset_busy%0d", i), 32'(busy_v[i]), 32'd0);
            chk($sformatf("reset_done%0d", i), 32'(done_v[i]), 32'd0);
        end
        reset = 1'b0;

        for (int k = 0; k < 6; k++)
            run_frame($sformatf("vec%0d", k), vecs[k].inst, vecs[k].d, vecs[k].exp,
                      vecs[k].ticks);

        // back-to-back frames chained off the done pulse
        start = done_cnt[0];
        send(0, 8'h00);
        wait_done(0, start, ok);
        chk("b2b0_done_seen", 32'(ok), 32'd1);
        check_frame("b2b0", 0, 12'h200, 160);
        din = 8'hFF;
        wr[0] = 1'b1;
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        chk("b2b1_no_gap", 32'(busy_v[0]), 32'd1);
        wait_done(0, start + 1, ok);
        chk("b2b1_done_seen", 32'(ok), 32'd1);
        check_frame("b2b1", 0, 12'h3FE, 160);
        din = 8'h3C;
        wr[0] = 1'b1;
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        chk("b2b2_no_gap", 32'(busy_v[0]), 32'd1);
        wait_done(0, start + 2, ok);
        chk("b2b2_done_seen", 32'(ok), 32'd1);
        check_frame("b2b2", 0, 12'h278, 160);

        // write while busy is ignored
        start = done_cnt[0];
        send(0, 8'hA5);
        wait_tick(0, 40, ok);
        chk("busywr_reach", 32'(ok), 32'd1);
        din = 8'h55;
        wr[0] = 1'b1;
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        wait_done(0, start, ok);
        chk("busywr_done_seen", 32'(ok), 32'd1);
        check_frame("busywr", 0, 12'h34A, 160);
        repeat (300) @(negedge clk);
        #1;
        chk("busywr_one_done", done_cnt[0], start + 1);
        chk("busywr_idle", 32'(busy_v[0]), 32'd0);

        // asynchronous reset during data bit 3
        send(0, 8'hA5);
        wait_tick(0, 69, ok);
        chk("rst_reach", 32'(ok), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_tx", 32'(tx_v[0]), 32'd1);
        chk("rst_busy", 32'(busy_v[0]), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        run_frame("after_rst", 0, 8'hA5, 12'h34A, 160);

        // baud tick stalled for 100 clk during data bit 5, two stop bits
        start = done_cnt[2];
        send(2, 8'h07);
        wait_tick(2, 100, ok);
        chk("stall_reach", 32'(ok), 32'd1);
        @(negedge clk);
        hold = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        ref_tx = tx_v[2];
        ref_tick = tick_n[2];
        steady = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #1;
            if (tx_v[2] !== ref_tx) steady = 1'b0;
        end
        chk("stall_tx_const", 32'(steady), 32'd1);
        chk("stall_tx_bit5", 32'(ref_tx), 32'd0);
        chk("stall_no_ticks", tick_n[2], ref_tick);
        hold = 1'b0;
        wait_done(2, start, ok);
        chk("stall_done_seen", 32'(ok), 32'd1);
        check_frame("stall", 2, 12'hC0E, 192);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
